// File: rtl/pipelined_memory.sv
// Row-organised lane-masked memory with a 1-cycle read into a 2-entry response FIFO.
// Optional PIPELINED_MEMORY_WR_BYPASS_EN forwards same-edge masked write lanes into the read.
module pipelined_memory #(
    parameter int DATA_WIDTH   = 8,
    parameter int SIZE         = 1024,
    parameter int LANES        = 4,
    parameter int ROWS         = SIZE / LANES,
    parameter int ADDRESS_BITS = $clog2(ROWS + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_valid,
    output logic                          write_ready,
    input  logic [ADDRESS_BITS-1:0]       write_address,
    input  logic [LANES-1:0]              write_mask,
    input  logic [LANES*DATA_WIDTH-1:0]   write_data,
    input  logic                          read_req_valid,
    output logic                          read_req_ready,
    input  logic [ADDRESS_BITS-1:0]       read_address,
    output logic                          read_resp_valid,
    input  logic                          read_resp_ready,
    output logic [LANES*DATA_WIDTH-1:0]   read_resp_data,
    output logic                          read_resp_error
);

    localparam int ROW_W    = LANES * DATA_WIDTH;
    localparam int IDX_BITS = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ADDRESS_BITS-1:0] ROWS_A = ADDRESS_BITS'(ROWS);

    logic [ROW_W-1:0] mem_q [0:ROWS-1];

    logic [ROW_W-1:0] fifo_data_q [0:1];
    logic             fifo_err_q  [0:1];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;

    logic                wr_en;
    logic                wr_in_range;
    logic                rd_in_range;
    logic                push;
    logic                pop;
    logic [IDX_BITS-1:0] wr_idx;
    logic [IDX_BITS-1:0] rd_idx;
    logic [ROW_W-1:0]    rd_data_d;
    logic                rd_err_d;

    assign write_ready    = ~reset;
    assign read_req_ready = ~reset && (count_q < 2'd2);
    assign read_resp_valid = ~reset && (count_q != 2'd0);

    assign wr_en       = write_valid && write_ready;
    assign wr_in_range = write_address < ROWS_A;
    assign rd_in_range = read_address < ROWS_A;
    assign wr_idx      = write_address[IDX_BITS-1:0];
    assign rd_idx      = read_address[IDX_BITS-1:0];

    assign push = read_req_valid && read_req_ready;
    assign pop  = read_resp_valid && read_resp_ready;

    always_comb begin
        rd_data_d = '0;
        rd_err_d  = 1'b1;
        if (rd_in_range) begin
            rd_err_d  = 1'b0;
            rd_data_d = mem_q[rd_idx];
`ifdef PIPELINED_MEMORY_WR_BYPASS_EN
            for (int i = 0; i < LANES; i++) begin
                if (wr_en && wr_in_range && (write_address == read_address) && write_mask[i])
                    rd_data_d[i*DATA_WIDTH +: DATA_WIDTH] = write_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
`endif
        end
    end

    // Storage is intentionally not reset so contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (wr_en && wr_in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (write_mask[i])
                    mem_q[wr_idx][i*DATA_WIDTH +: DATA_WIDTH] <= write_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_data_q[wr_ptr_q] <= rd_data_d;
            fifo_err_q[wr_ptr_q]  <= rd_err_d;
        end
    end

    always_comb begin
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push) wr_ptr_q <= ~wr_ptr_q;
            if (pop)  rd_ptr_q <= ~rd_ptr_q;
        end
    end

    assign read_resp_data  = read_resp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign read_resp_error = read_resp_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule

// File: tb/tb_pipelined_memory.sv
// Randomised bench for pipelined_memory against a queue/array reference model.
// Honours PIPELINED_MEMORY_WR_BYPASS_EN when it is defined for the build.
module tb_pipelined_memory;

    localparam int DW = 8;
    localparam int SZ = 16;
    localparam int LN = 4;
    localparam int AB = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_valid;
    logic          write_ready;
    logic [AB-1:0] write_address;
    logic [LN-1:0] write_mask;
    logic [31:0]   write_data;
    logic          read_req_valid;
    logic          read_req_ready;
    logic [AB-1:0] read_address;
    logic          read_resp_valid;
    logic          read_resp_ready;
    logic [31:0]   read_resp_data;
    logic          read_resp_error;

    always #5 clk = ~clk;

    pipelined_memory #(.DATA_WIDTH(DW), .SIZE(SZ), .LANES(LN)) dut (
        .clk(clk), .reset(reset),
        .write_valid(write_valid), .write_ready(write_ready),
        .write_address(write_address), .write_mask(write_mask), .write_data(write_data),
        .read_req_valid(read_req_valid), .read_req_ready(read_req_ready),
        .read_address(read_address),
        .read_resp_valid(read_resp_valid), .read_resp_ready(read_resp_ready),
        .read_resp_data(read_resp_data), .read_resp_error(read_resp_error)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mm [0:3];
    logic [32:0] exp_q [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check at negedge against the model, update model at posedge.
    task automatic cycle(input logic rst, input logic wv, input logic [2:0] wa, input logic [3:0] wm,
                         input logic [31:0] wd, input logic rv, input logic [2:0] ra, input logic rr);
        logic        push, pop, exp_rdy;
        logic [31:0] row;
        logic [32:0] ent;
        reset = rst; write_valid = wv; write_address = wa; write_mask = wm; write_data = wd;
        read_req_valid = rv; read_address = ra; read_resp_ready = rr;
        @(negedge clk);
        exp_rdy = !rst && (exp_q.size() < 2);
        chk("write_ready", {63'd0, write_ready}, {63'd0, !rst});
        chk("req_ready", {63'd0, read_req_ready}, {63'd0, exp_rdy});
        chk("resp_valid", {63'd0, read_resp_valid}, {63'd0, (!rst && exp_q.size() > 0)});
        if (rst) begin
            chk("rst_data", {32'd0, read_resp_data}, 64'd0);
            chk("rst_err", {63'd0, read_resp_error}, 64'd0);
        end else if (exp_q.size() > 0) begin
            chk("resp_data", {32'd0, read_resp_data}, {32'd0, exp_q[0][31:0]});
            chk("resp_err", {63'd0, read_resp_error}, {63'd0, exp_q[0][32]});
        end
        push = rv && exp_rdy;
        pop  = !rst && (exp_q.size() > 0) && rr;
        if (ra < 3'd4) begin
            row = mm[ra[1:0]];
`ifdef PIPELINED_MEMORY_WR_BYPASS_EN
            if (wv && !rst && wa == ra)
                for (int i = 0; i < 4; i++)
                    if (wm[i]) row[i*8 +: 8] = wd[i*8 +: 8];
`endif
            ent = {1'b0, row};
        end else begin
            ent = {1'b1, 32'h0};
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
        end else begin
            if (pop)  void'(exp_q.pop_front());
            if (push) exp_q.push_back(ent);
            if (wv && wa < 3'd4)
                for (int i = 0; i < 4; i++)
                    if (wm[i]) mm[wa[1:0]][i*8 +: 8] = wd[i*8 +: 8];
        end
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] m, input logic [31:0] d);
        cycle(1'b0, 1'b1, a, m, d, 1'b0, 3'd0, 1'b1);
    endtask

    task automatic rd(input logic [2:0] a, input logic rr);
        cycle(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, a, rr);
    endtask

    task automatic idle(input logic rr);
        cycle(1'b0, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0, rr);
    endtask

    initial begin
        logic [31:0] exp38;
        reset = 1'b1; write_valid = 1'b0; write_address = '0; write_mask = '0; write_data = '0;
        read_req_valid = 1'b0; read_address = '0; read_resp_ready = 1'b0;
        for (int r = 0; r < 4; r++) mm[r] = 32'h0;
        @(posedge clk); #1;
        cycle(1'b1, 1'b0, 3'd0, 4'h0, 32'h0, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 1'b1, 3'd1, 4'hF, 32'h5A5A5A5A, 1'b1, 3'd1, 1'b0);

        for (int r = 0; r < 4; r++) wr(3'(r), 4'hF, 32'h10203040 + 32'(r));

        // Full-row write then read of row 2
        wr(3'd2, 4'hF, 32'h44332211);
        rd(3'd2, 1'b1);
        chk("r034_valid", {63'd0, read_resp_valid}, 64'd1);
        chk("r034_data", {32'd0, read_resp_data}, 64'h44332211);
        chk("r034_err", {63'd0, read_resp_error}, 64'd0);
        idle(1'b1);

        // Partial-mask write
        wr(3'd2, 4'b0101, 32'hAABBCCDD);
        rd(3'd2, 1'b1);
        chk("r035_data", {32'd0, read_resp_data}, 64'h44BB22DD);
        idle(1'b1);

        // Stall: two reads fill the FIFO, third is refused until drained
        rd(3'd0, 1'b0);
        rd(3'd1, 1'b0);
        chk("r036_full", {63'd0, read_req_ready}, 64'd0);
        rd(3'd2, 1'b0);
        chk("r036_hold", {32'd0, read_resp_data}, 64'h10203040);
        rd(3'd2, 1'b1);
        chk("r036_second", {32'd0, read_resp_data}, 64'h10203041);
        rd(3'd2, 1'b1);
        chk("r036_third", {32'd0, read_resp_data}, 64'h44BB22DD);
        idle(1'b1);
        idle(1'b1);

        // Out-of-range write and read
        wr(3'd5, 4'hF, 32'hFFFFFFFF);
        rd(3'd5, 1'b1);
        chk("r037_data", {32'd0, read_resp_data}, 64'd0);
        chk("r037_err", {63'd0, read_resp_error}, 64'd1);
        for (int r = 0; r < 4; r++) rd(3'(r), 1'b1);
        idle(1'b1);

        // Same-edge write and read of one row
        wr(3'd1, 4'hF, 32'h11111111);
        cycle(1'b0, 1'b1, 3'd1, 4'hF, 32'h22222222, 1'b1, 3'd1, 1'b1);
`ifdef PIPELINED_MEMORY_WR_BYPASS_EN
        exp38 = 32'h22222222;
`else
        exp38 = 32'h11111111;
`endif
        chk("r038_data", {32'd0, read_resp_data}, {32'd0, exp38});
        idle(1'b1);

        // Reset with a full FIFO, storage must survive
        rd(3'd0, 1'b0);
        rd(3'd2, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 4'h0, 32'h0, 1'b1, 3'd3, 1'b0);
        chk("r039_flush", {63'd0, read_resp_valid}, 64'd0);
        rd(3'd2, 1'b1);
        chk("r039_data", {32'd0, read_resp_data}, 64'h44BB22DD);
        idle(1'b1);

        for (int n = 0; n < 500; n++) begin
            cycle(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)),
                  4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 5)),
                  1'($urandom_range(0, 2) != 0));
        end
        for (int n = 0; n < 3; n++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pipelined_memory.md
PIPELINED_MEMORY -- requirements
Module: pipelined_memory

Interface
REQ-001 The block SHALL use one clock, clk, and a synchronous active-high reset, reset; every register updates only on the rising edge of clk.
REQ-002 Parameter: DATA_WIDTH, 8, bits per word.
REQ-003 Parameter: SIZE, 1024, total words stored; SHALL be a multiple of LANES.
REQ-004 Parameter: LANES, 4, words per row, i.e. per access.
REQ-005 Derived: ROWS = SIZE/LANES; ADDRESS_BITS = $clog2(ROWS+1).
REQ-006 clk  input  1  clock.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 write_valid  input  1  write request present.
REQ-009 write_ready  output  1  write can be accepted.
REQ-010 write_address  input  ADDRESS_BITS  row index.
REQ-011 write_mask  input  LANES  per-lane write enable; bit i selects lane i.
REQ-012 write_data  input  LANES*DATA_WIDTH  lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-013 read_req_valid  input  1  read request present.
REQ-014 read_req_ready  output  1  read request can be accepted.
REQ-015 read_address  input  ADDRESS_BITS  row index.
REQ-016 read_resp_valid  output  1  response available.
REQ-017 read_resp_ready  input  1  consumer accepts the response.
REQ-018 read_resp_data  output  LANES*DATA_WIDTH  row data, same lane packing as write_data.
REQ-019 read_resp_error  output  1  the response's address was out of range.

Function
REQ-020 A transfer SHALL occur on any channel only in a cycle where both valid and ready are high at the rising edge.
REQ-021 write_ready SHALL be 1 whenever reset is low; an accepted write updates the masked lanes of the row at that edge, and unmasked lanes are unchanged.
REQ-022 A write with write_address >= ROWS SHALL be accepted and SHALL have no effect on storage.
REQ-023 An accepted read SHALL sample the row into a 2-entry response FIFO at the acceptance edge, so read_resp_valid rises in the next cycle (latency 1).
REQ-024 read_req_ready SHALL equal (FIFO count < 2); it is registered-state only, with no combinational path from read_resp_ready.
REQ-025 A read with read_address >= ROWS SHALL produce a response with read_resp_data = 0 and read_resp_error = 1; in-range responses carry error = 0.
REQ-026 Responses SHALL be returned in request order.
REQ-027 read_resp_data and read_resp_error SHALL hold stable while read_resp_valid=1 and read_resp_ready=0.
REQ-028 A push and a pop in the same cycle SHALL leave the count unchanged, with throughput of one read per cycle sustained while read_resp_ready=1.
REQ-029 Same-edge read and write to the same row: behaviour is set by REQ-033.
REQ-030 Storage SHALL NOT be reset; its contents are undefined until written.

Reset
REQ-031 While reset=1, the following SHALL hold: write_ready=0, read_req_ready=0, read_resp_valid=0, read_resp_data=0, read_resp_error=0, FIFO count=0; any write presented is ignored.
REQ-032 Reset asserted mid-operation SHALL discard all pending responses at the next edge; storage contents are retained.

Configuration
REQ-033 Macro PIPELINED_MEMORY_WR_BYPASS_EN, when defined: a same-edge read of a row being written SHALL return the new data in the masked lanes and the old data in the other lanes. When undefined, that read SHALL return the old data for all lanes (read-first).

Verification (DATA_WIDTH=8, SIZE=16, LANES=4, so ROWS=4 and ADDRESS_BITS=3)
REQ-034 Write row 2 with mask 4'b1111 and data 0x44332211; read row 2 -> one cycle later resp_valid=1, data=0x44332211, error=0.
REQ-035 Write row 2 with mask 4'b0101 and data 0xAABBCCDD; read row 2 -> data=0x44BB22DD.
REQ-036 Hold read_resp_ready=0 and issue 3 back-to-back reads of rows 0, 1, 2 -> the first two are accepted, read_req_ready=0 on the third; release ready -> responses arrive in order 0, 1, 2 and data is held stable while stalled.
REQ-037 Write row 5 with data 0xFFFFFFFF, then read row 5 -> data=0, error=1, and rows 0-3 are unchanged.
REQ-038 With row 1 = 0x11111111, apply a same-edge write of 0x22222222 (mask 4'b1111) and a read of row 1 -> response is 0x22222222 with the macro defined, 0x11111111 without it.
REQ-039 Fill the FIFO with 2 responses, then assert reset for 1 cycle -> resp_valid=0 and both ready signals=0 during reset; after reset, a read of a previously written row returns its pre-reset data.
